ikascc_wram_scheduler: RTL and testbench

//  Time-division scheduler for the single-port 128-byte SCC wave RAM. Shares it between the
//  5-channel wavetable sample fetch and CPU bus read/write requests from the bus synchronizer.

---
 rtl/ikascc_wram_scheduler.sv | 166 ++++++++++++++++
 tb/tb_ikascc_wram_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ikascc_wram_scheduler.sv
// Time-division scheduler for the single-port SCC wave RAM: five fixed sample-fetch slots
// followed by three CPU slots fed from a small request FIFO.
module ikascc_wram_scheduler #(
    parameter int unsigned CPU_FIFO_DEPTH = 2,
    parameter int unsigned CH4_BANK       = 3
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST_n,
    input  logic        i_MCLK_PCEN_n,
    input  logic        i_CPU_RDRQ,
    input  logic        i_CPU_WRRQ,
    input  logic [6:0]  i_CPU_ADDR,
    input  logic [7:0]  i_CPU_DI,
    output logic [7:0]  o_CPU_DO,
    output logic        o_CPU_DVALID,
    output logic        o_CPU_OVF,
    input  logic [24:0] i_PTRS,
    output logic [7:0]  o_SMPL,
    output logic [2:0]  o_SMPL_CH,
    output logic        o_SMPL_VALID,
    output logic        o_FRAME,
    output logic [6:0]  o_RAM_ADDR,
    output logic        o_RAM_WE,
    output logic [7:0]  o_RAM_DO,
    input  logic [7:0]  i_RAM_DI
);

    localparam int unsigned PtrW = (CPU_FIFO_DEPTH > 1) ? $clog2(CPU_FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(CPU_FIFO_DEPTH + 1);
    localparam logic [1:0] Ch4Bank = 2'(CH4_BANK);

    typedef enum logic [1:0] {IssNone, IssFetch, IssCpuRd} iss_e;

    logic            tick;
    logic [2:0]      slot_q;
    iss_e            iss_q, iss_d;
    logic [2:0]      iss_ch_q, iss_ch_d;
    logic [6:0]      ram_addr_q, ram_addr_d;
    logic            ram_we_q, ram_we_d;
    logic [7:0]      ram_do_q, ram_do_d;
    logic            frame_q;
    logic [7:0]      smpl_q;
    logic [2:0]      smpl_ch_q;
    logic            smpl_valid_q;
    logic [7:0]      cpu_do_q;
    logic            cpu_dvalid_q;
    logic            ovf_q;

    // Each FIFO entry is {we, addr[6:0], data[7:0]}.
    logic [15:0]     fifo_mem [CPU_FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            req, full, push, pop;
    logic [15:0]     head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(CPU_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tick = ~i_MCLK_PCEN_n;
    assign req  = i_CPU_WRRQ | i_CPU_RDRQ;
    assign full = (count_q == CntW'(CPU_FIFO_DEPTH));
    assign pop  = (slot_q >= 3'd5) && (count_q != '0);
    // A full FIFO still accepts when the head leaves in the same tick.
    assign push = req && (!full || pop);
    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_we_d   = 1'b0;
        ram_do_d   = ram_do_q;
        iss_d      = IssNone;
        iss_ch_d   = iss_ch_q;
        case (slot_q)
            3'd0: begin ram_addr_d = {2'd0, i_PTRS[4:0]};   iss_d = IssFetch; iss_ch_d = 3'd0; end
            3'd1: begin ram_addr_d = {2'd1, i_PTRS[9:5]};   iss_d = IssFetch; iss_ch_d = 3'd1; end
            3'd2: begin ram_addr_d = {2'd2, i_PTRS[14:10]}; iss_d = IssFetch; iss_ch_d = 3'd2; end
            3'd3: begin ram_addr_d = {2'd3, i_PTRS[19:15]}; iss_d = IssFetch; iss_ch_d = 3'd3; end
            3'd4: begin ram_addr_d = {Ch4Bank, i_PTRS[24:20]}; iss_d = IssFetch; iss_ch_d = 3'd4; end
            default: begin
                if (pop) begin
                    ram_we_d   = head[15];
                    ram_addr_d = head[14:8];
                    ram_do_d   = head[7:0];
                    iss_d      = head[15] ? IssNone : IssCpuRd;
                end
            end
        endcase
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            slot_q       <= '0;
            iss_q        <= IssNone;
            iss_ch_q     <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_do_q     <= '0;
            frame_q      <= 1'b0;
            smpl_q       <= '0;
            smpl_ch_q    <= '0;
            smpl_valid_q <= 1'b0;
            cpu_do_q     <= '0;
            cpu_dvalid_q <= 1'b0;
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else if (tick) begin
            slot_q     <= slot_q + 3'd1;
            frame_q    <= (slot_q == 3'd0);
            iss_q      <= iss_d;
            iss_ch_q   <= iss_ch_d;
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_do_q   <= ram_do_d;
            // Return stage: the RAM answers the access issued on the previous tick.
            smpl_valid_q <= (iss_q == IssFetch);
            if (iss_q == IssFetch) begin
                smpl_q    <= i_RAM_DI;
                smpl_ch_q <= iss_ch_q;
            end
            cpu_dvalid_q <= (iss_q == IssCpuRd);
            if (iss_q == IssCpuRd) begin
                cpu_do_q <= i_RAM_DI;
            end
            if (req && !push) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (tick && push) begin
            fifo_mem[wr_ptr_q] <= {i_CPU_WRRQ, i_CPU_ADDR, i_CPU_DI};
        end
    end

    assign o_CPU_DO     = cpu_do_q;
    assign o_CPU_DVALID = cpu_dvalid_q;
    assign o_CPU_OVF    = ovf_q;
    assign o_SMPL       = smpl_q;
    assign o_SMPL_CH    = smpl_ch_q;
    assign o_SMPL_VALID = smpl_valid_q;
    assign o_FRAME      = frame_q;
    assign o_RAM_ADDR   = ram_addr_q;
    assign o_RAM_WE     = ram_we_q;
    assign o_RAM_DO     = ram_do_q;

endmodule

// File: tb/tb_ikascc_wram_scheduler.sv
// Directed bench for the wave RAM scheduler with a behavioural 128-byte RAM model.
module tb_ikascc_wram_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcen_n;
    logic        cpu_rdrq, cpu_wrrq;
    logic [6:0]  cpu_addr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        cpu_dvalid, cpu_ovf;
    logic [24:0] ptrs;
    logic [7:0]  smpl;
    logic [2:0]  smpl_ch;
    logic        smpl_valid, frame;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_do, ram_di;

    logic [7:0]  ram [128];
    logic        fill, poke_en;
    logic [6:0]  poke_addr;
    logic [7:0]  poke_data;

    int passed = 0;
    int total  = 0;
    int bus_slot;
    logic [6:0] exp_addr [5];

    always #5 clk = ~clk;

    ikascc_wram_scheduler #(.CPU_FIFO_DEPTH(2), .CH4_BANK(3)) dut (
        .i_EMUCLK(clk), .i_RST_n(rst_n), .i_MCLK_PCEN_n(pcen_n),
        .i_CPU_RDRQ(cpu_rdrq), .i_CPU_WRRQ(cpu_wrrq), .i_CPU_ADDR(cpu_addr), .i_CPU_DI(cpu_di),
        .o_CPU_DO(cpu_do), .o_CPU_DVALID(cpu_dvalid), .o_CPU_OVF(cpu_ovf),
        .i_PTRS(ptrs), .o_SMPL(smpl), .o_SMPL_CH(smpl_ch), .o_SMPL_VALID(smpl_valid),
        .o_FRAME(frame), .o_RAM_ADDR(ram_addr), .o_RAM_WE(ram_we), .o_RAM_DO(ram_do),
        .i_RAM_DI(ram_di)
    );

    // Initial contents are addr+1 so every fetched byte identifies its address.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 128; i++) ram[i] <= 8'(i + 1);
        end else if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (ram_we) begin
            ram[ram_addr] <= ram_do;
        end
    end
    assign ram_di = ram[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus_slot = (bus_slot + 1) % 8;
    endtask

    task automatic goto_slot(input int s);
        for (int i = 0; i < 8 && bus_slot != s; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; pcen_n = 1'b0; cpu_rdrq = 1'b0; cpu_wrrq = 1'b0;
        cpu_addr = '0; cpu_di = '0; ptrs = '0;
        fill = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        exp_addr[0] = 7'h00; exp_addr[1] = 7'h20; exp_addr[2] = 7'h40;
        exp_addr[3] = 7'h60; exp_addr[4] = 7'h60;
        repeat (3) @(posedge clk);
        #1;
        fill = 1'b0;
        check("rst_frame", frame, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_we", ram_we, 0);
        check("rst_smpl_valid", smpl_valid, 0);
        check("rst_dvalid", cpu_dvalid, 0);
        check("rst_ovf", cpu_ovf, 0);
        rst_n = 1'b1;
        bus_slot = 7;

        // 1: free-running frame with all pointers at 0
        for (int k = 0; k < 16; k++) begin
            step();
            check("t1_frame", frame, (k % 8 == 0) ? 1 : 0);
            check("t1_we", ram_we, 0);
            if (k % 8 < 5) check("t1_addr", ram_addr, exp_addr[k % 8]);
            else check("t1_addr_hold", ram_addr, 7'h60);
            if (k >= 1 && (k - 1) % 8 < 5) begin
                check("t1_svalid", smpl_valid, 1);
                check("t1_sch", smpl_ch, (k - 1) % 8);
                check("t1_smpl", smpl, exp_addr[(k - 1) % 8] + 1);
            end else begin
                check("t1_svalid0", smpl_valid, 0);
            end
        end

        // 2: write 0x5A to 0x23 at slot 2, then read it back
        goto_slot(1);
        cpu_wrrq = 1'b1; cpu_addr = 7'h23; cpu_di = 8'h5A;
        step();
        cpu_wrrq = 1'b0;
        goto_slot(5);
        check("t2_we", ram_we, 1);
        check("t2_addr", ram_addr, 7'h23);
        check("t2_do", ram_do, 8'h5A);
        step();
        check("t2_we_off", ram_we, 0);
        check("t2_addr_hold", ram_addr, 7'h23);
        cpu_rdrq = 1'b1; cpu_addr = 7'h23;
        step();
        cpu_rdrq = 1'b0;
        goto_slot(5);
        check("t2_rd_addr", ram_addr, 7'h23);
        check("t2_rd_we", ram_we, 0);
        step();
        check("t2_dvalid", cpu_dvalid, 1);
        check("t2_cpu_do", cpu_do, 8'h5A);
        step();
        check("t2_dvalid_off", cpu_dvalid, 0);
        check("t2_cpu_do_hold", cpu_do, 8'h5A);

        // 3: three back-to-back writes into a 2-deep FIFO
        goto_slot(7);
        check("t3_ovf_pre", cpu_ovf, 0);
        cpu_wrrq = 1'b1; cpu_addr = 7'h10; cpu_di = 8'h11;
        step();
        cpu_addr = 7'h11; cpu_di = 8'h22;
        step();
        cpu_addr = 7'h12; cpu_di = 8'h33;
        step();
        cpu_wrrq = 1'b0;
        check("t3_ovf", cpu_ovf, 1);
        goto_slot(5);
        check("t3_we0", ram_we, 1);
        check("t3_addr0", ram_addr, 7'h10);
        check("t3_do0", ram_do, 8'h11);
        step();
        check("t3_we1", ram_we, 1);
        check("t3_addr1", ram_addr, 7'h11);
        check("t3_do1", ram_do, 8'h22);
        step();
        check("t3_we2", ram_we, 0);
        check("t3_dropped", ram[7'h12], 8'h13);
        check("t3_ovf_sticky", cpu_ovf, 1);

        // 4: ch1 pointer 0x1F with RAM[0x3F]=0x80, ch4 pointer 7
        poke_en = 1'b1; poke_addr = 7'h3F; poke_data = 8'h80;
        ptrs = (25'd7 << 20) | (25'h1F << 5);
        step();
        poke_en = 1'b0;
        goto_slot(1);
        check("t4_addr1", ram_addr, 7'h3F);
        step();
        check("t4_svalid", smpl_valid, 1);
        check("t4_sch", smpl_ch, 1);
        check("t4_smpl", smpl, 8'h80);
        goto_slot(4);
        check("t4_addr4", ram_addr, 7'h67);
        step();
        check("t4_sch4", smpl_ch, 4);
        check("t4_smpl4", smpl, 8'h68);

        // 5: simultaneous RD+WR queues only the write; gated ticks freeze everything
        goto_slot(7);
        cpu_rdrq = 1'b1; cpu_wrrq = 1'b1; cpu_addr = 7'h05; cpu_di = 8'h77;
        step();
        cpu_rdrq = 1'b0; cpu_wrrq = 1'b0;
        goto_slot(5);
        check("t5_we", ram_we, 1);
        check("t5_addr", ram_addr, 7'h05);
        check("t5_do", ram_do, 8'h77);
        step();
        check("t5_no_second", ram_we, 0);
        check("t5_dvalid6", cpu_dvalid, 0);
        check("t5_addr_hold", ram_addr, 7'h05);
        step();
        check("t5_dvalid7", cpu_dvalid, 0);
        goto_slot(2);
        pcen_n = 1'b1; ptrs = '1;
        cpu_wrrq = 1'b1; cpu_addr = 7'h7F; cpu_di = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t5_frz_svalid", smpl_valid, 1);
            check("t5_frz_sch", smpl_ch, 1);
            check("t5_frz_smpl", smpl, 8'h80);
            check("t5_frz_addr", ram_addr, 7'h40);
            check("t5_frz_frame", frame, 0);
        end
        pcen_n = 1'b0; cpu_wrrq = 1'b0;
        ptrs = (25'd7 << 20) | (25'h1F << 5);
        goto_slot(5);
        check("t5_gated_req", ram_we, 0);
        check("t5_addr_after", ram_addr, 7'h67);
        check("t5_ram7f", ram[7'h7F], 8'h80);

        // 6: reset during an in-flight CPU read
        goto_slot(7);
        cpu_rdrq = 1'b1; cpu_addr = 7'h23;
        step();
        cpu_rdrq = 1'b0;
        goto_slot(5);
        check("t6_rd_addr", ram_addr, 7'h23);
        rst_n = 1'b0;
        #1;
        check("t6_rst_addr", ram_addr, 0);
        check("t6_rst_do", cpu_do, 0);
        check("t6_rst_ovf", cpu_ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_dvalid", cpu_dvalid, 0);
        rst_n = 1'b1;
        bus_slot = 7;
        step();
        check("t6_frame", frame, 1);
        check("t6_addr0", ram_addr, 7'h00);
        check("t6_dvalid0", cpu_dvalid, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_dvalid", cpu_dvalid, 0);
        end
        check("t6_empty_we", ram_we, 0);
        check("t6_empty_addr", ram_addr, 7'h67);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
